// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared glyph constants, hex-to-segment decode function and
//               parameter legality helpers for the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment patterns, bit order {A,B,C,D,E,F,G}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b1001001;
    localparam logic [6:0] SEG_ALL   = 7'b0000000;

    // Nibble to glyph; an unknown nibble (X/Z in simulation) falls to ERR
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_ERR;
        endcase
        return seg;
    endfunction

    // Legal digit count is 1..16
    function automatic bit num_digits_ok(input int n);
        return (n >= 1) && (n <= 16);
    endfunction

    // Each digit must be held for at least two cycles
    function automatic bit refresh_div_ok(input int d);
        return d >= 2;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph
// Description : Combinational nibble to active-low 7-segment glyph decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup through the shared package decoder
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule : seg7_glyph
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed N-digit hex driver for a common-anode
//               7-segment bank with enable masking, decimal points,
//               leading-zero blanking and lamp test.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic                    lamp_test,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              disp,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // Elaboration-time rejection of illegal parameter sets
    if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_num_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 1..16");
    end
    if (!refresh_div_ok(REFRESH_DIV)) begin : g_bad_refresh_div
        $error("seg7_scan_driver: REFRESH_DIV must be >= 2");
    end

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_data;
    logic [NUM_DIGITS-1:0]   r_dp_snap;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_disp;
    logic                    r_dp;

    logic                    w_tc;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [3:0]              w_nib;
    logic                    w_sel_lz;
    logic                    w_sel_dp;
    logic                    w_sel_en;
    logic [6:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_anode_nxt;
    logic [6:0]              w_disp_nxt;
    logic                    w_dp_nxt;

    assign w_tc = (r_cnt == CNT_W'(REFRESH_DIV - 1));

    // Refresh counter and digit index; index advances on terminal count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Snapshot registers, updated only on the load strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_dp_snap <= '0;
            r_en      <= '0;
        end else if (load) begin
            r_data    <= data;
            r_dp_snap <= dp_in;
            r_en      <= digit_en;
        end
    end

    // Leading-zero mask: a digit blanks when it and all higher digits are 0;
    // digit 0 is never part of the mask so an all-zero word still shows "0"
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (r_data[4*i +: 4] == 4'h0);
            w_lz_mask[i] = zero_run;
        end
    end

    // Select the current digit's nibble and per-digit attributes
    always_comb begin
        w_nib    = 4'h0;
        w_sel_lz = 1'b0;
        w_sel_dp = 1'b0;
        w_sel_en = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib    = r_data[4*i +: 4];
                w_sel_lz = w_lz_mask[i];
                w_sel_dp = r_dp_snap[i];
                w_sel_en = r_en[i];
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble (w_nib),
        .seg    (w_glyph)
    );

    // Output priority: disabled > lamp test > leading-zero blank > glyph
    always_comb begin
        w_anode_nxt = '1;
        w_disp_nxt  = SEG_BLANK;
        w_dp_nxt    = 1'b1;
        if (w_sel_en) begin
            w_anode_nxt = ~(NUM_DIGITS'(1) << r_idx);
            if (lamp_test) begin
                w_disp_nxt = SEG_ALL;
                w_dp_nxt   = 1'b0;
            end else if (blank_lz && w_sel_lz) begin
                w_disp_nxt = SEG_BLANK;
                w_dp_nxt   = ~w_sel_dp;
            end else begin
                w_disp_nxt = w_glyph;
                w_dp_nxt   = ~w_sel_dp;
            end
        end
    end

    // Anode, segments and DP registered together so they never disagree
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode <= '1;
            r_disp  <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_anode <= w_anode_nxt;
            r_disp  <= w_disp_nxt;
            r_dp    <= w_dp_nxt;
        end
    end

    assign anode     = r_anode;
    assign disp      = r_disp;
    assign dp        = r_dp;
    assign digit_idx = r_idx;

endmodule : seg7_scan_driver
`default_nettype wire
